// File: rtl/ofdm_cp_inserter_pkg.sv
// Shared constants and types for the OFDM cyclic-prefix inserter.
// Symbol geometry lives here so the RAM, interface and top agree on widths.
package ofdm_pkg;

  localparam int DW   = 16;
  localparam int NFFT = 64;
  localparam int NCP  = 16;
  localparam int NSYM = NFFT + NCP;
  localparam int AW   = $clog2(NFFT);
  localparam int IDXW = $clog2(NSYM);

  typedef struct packed {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
  } iq_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_CP,
    RD_BODY
  } cp_rd_state_e;

  // First bank address read for the prefix (the tail of the symbol).
  localparam logic [AW-1:0] CP_START  = AW'(NFFT - NCP);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NFFT - 1);

endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// Sample-stream bundle between the IFFT, the CP inserter and the DAC path.
// The slave view belongs to the inserter; the master view to whoever drives it.
interface ofdm_cp_inserter_if;
  import ofdm_pkg::*;

  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic                 in_valid;
  logic                 in_ready;

  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sos;
  logic                 out_cp;
  logic [IDXW-1:0]      out_idx;

  modport slave (
    input  in_i, in_q, in_valid, out_ready,
    output in_ready, out_i, out_q, out_valid, out_sos, out_cp, out_idx
  );

  modport master (
    output in_i, in_q, in_valid, out_ready,
    input  in_ready, out_i, out_q, out_valid, out_sos, out_cp, out_idx
  );

endinterface

// File: rtl/ofdm_cp_inserter_ram.sv
// Two-bank symbol store: synchronous write, asynchronous read, address {bank, idx}.
// Small enough to sit in distributed RAM, which is what makes the async read cheap.
module cp_pingpong_ram
  import ofdm_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [AW:0] waddr,
  input  iq_t         wdata,
  input  logic [AW:0] raddr,
  output iq_t         rdata
);

  iq_t mem_q [0:2*NFFT-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Tx cyclic-prefix inserter: buffers NFFT-sample symbols in a ping-pong RAM and
// replays each as its last NCP samples followed by the whole symbol.
module ofdm_cp_inserter
  import ofdm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ofdm_cp_inserter_if.slave  io
);

  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic [1:0]      full_q, full_d;
  logic            in_ready_q, in_ready_d;
  logic            wr_fire, wr_done;
  iq_t             wr_data;

  cp_rd_state_e    rd_state_q, rd_state_d;
  logic            rd_bank_q, rd_bank_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [IDXW-1:0] pos_q, pos_d;
  logic            rd_free;
  logic            rd_emit;
  logic            rd_in_cp;
  logic [AW-1:0]   rd_addr_mux;
  logic [IDXW-1:0] rd_idx;
  iq_t             rd_data;

  logic            out_adv;
  logic            out_valid_q, out_valid_d;
  logic            out_sos_q, out_sos_d;
  logic            out_cp_q, out_cp_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  iq_t             out_iq_q, out_iq_d;

  assign wr_fire = io.in_valid & in_ready_q;
  assign wr_done = wr_fire && (wr_cnt_q == ADDR_LAST);
  assign wr_data = '{i: io.in_i, q: io.in_q};

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q ^ wr_done;
    if (wr_fire) begin
      wr_cnt_d = wr_done ? '0 : wr_cnt_q + AW'(1);
    end
  end

  // The writer only ever targets an empty bank and the reader only frees a
  // full one, so a set and a clear in the same cycle never hit the same bank.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_full
    assign full_d[gi] = (wr_done && (wr_bank_q == 1'(gi))) ||
                        (full_q[gi] && !(rd_free && (rd_bank_q == 1'(gi))));
  end

  // Registered ready: out_ready reaches in_ready only through the full flags.
  assign in_ready_d = !full_d[wr_bank_d];

  cp_pingpong_ram u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .wdata (wr_data),
    .raddr ({rd_bank_q, rd_addr_mux}),
    .rdata (rd_data)
  );

  assign out_adv = !out_valid_q | io.out_ready;

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_addr_d   = rd_addr_q;
    pos_d       = pos_q;
    rd_free     = 1'b0;
    rd_emit     = 1'b1;
    rd_in_cp    = 1'b1;
    rd_addr_mux = rd_addr_q;
    rd_idx      = pos_q;
    out_valid_d = out_valid_q;
    out_sos_d   = out_sos_q;
    out_cp_d    = out_cp_q;
    out_idx_d   = out_idx_q;
    out_iq_d    = out_iq_q;

    // Idle emits the first prefix sample directly so that a freshly filled
    // bank reaches the output register on the cycle its full flag appears.
    case (rd_state_q)
      RD_IDLE: begin
        rd_emit     = full_q[rd_bank_q];
        rd_addr_mux = CP_START;
        rd_idx      = '0;
      end
      RD_CP:   rd_in_cp = 1'b1;
      RD_BODY: rd_in_cp = 1'b0;
      default: rd_emit  = 1'b0;
    endcase

    if (out_adv) begin
      out_valid_d = rd_emit;
      if (rd_emit) begin
        out_iq_d  = rd_data;
        out_idx_d = rd_idx;
        out_sos_d = (rd_idx == '0);
        out_cp_d  = rd_in_cp;
        pos_d     = rd_idx + IDXW'(1);
        rd_addr_d = rd_addr_mux + AW'(1);
        if (rd_in_cp) begin
          rd_state_d = RD_CP;
          if (rd_addr_mux == ADDR_LAST) begin
            rd_state_d = RD_BODY;
            rd_addr_d  = '0;
          end
        end else if (rd_addr_mux == ADDR_LAST) begin
          rd_free    = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          pos_d      = '0;
          rd_addr_d  = CP_START;
          rd_state_d = full_q[~rd_bank_q] ? RD_CP : RD_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      in_ready_q  <= 1'b1;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= CP_START;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_sos_q   <= 1'b0;
      out_cp_q    <= 1'b0;
      out_idx_q   <= '0;
      out_iq_q    <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      in_ready_q  <= in_ready_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_sos_q   <= out_sos_d;
      out_cp_q    <= out_cp_d;
      out_idx_q   <= out_idx_d;
      out_iq_q    <= out_iq_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_i     = out_iq_q.i;
  assign io.out_q     = out_iq_q.q;
  assign io.out_valid = out_valid_q;
  assign io.out_sos   = out_sos_q;
  assign io.out_cp    = out_cp_q;
  assign io.out_idx   = out_idx_q;

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Bench for the CP inserter: a symbol-level golden model builds the expected
// 80-sample stream from every completed 64-sample input symbol.
module tb_ofdm_cp_inserter;
  import ofdm_pkg::*;

  typedef struct packed {
    logic [DW-1:0]   i;
    logic [DW-1:0]   q;
    logic [IDXW-1:0] idx;
    logic            cp;
    logic            sos;
  } samp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ofdm_cp_inserter_if io();

  ofdm_cp_inserter dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  samp_t         exp_q[$];
  samp_t         got_q[$];
  logic [DW-1:0] sym_i [NFFT];
  logic [DW-1:0] sym_q [NFFT];
  int            wpos, n_in, last_sym_cyc, stall_bad, max_run, cur_run, wraps;
  logic          prev_stall, have_prev;
  samp_t         held;
  logic [IDXW-1:0] prev_idx;

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    wpos = 0; n_in = 0; stall_bad = 0; max_run = 0; cur_run = 0; wraps = 0;
    prev_stall = 1'b0; have_prev = 1'b0;
  endtask

  // Golden CP rule: output k is sample NFFT-NCP+k for k<NCP, else sample k-NCP.
  task automatic push_symbol();
    for (int k = 0; k < NSYM; k++) begin
      samp_t s;
      int    a;
      a     = (k < NCP) ? (NFFT - NCP + k) : (k - NCP);
      s.i   = sym_i[a];
      s.q   = sym_q[a];
      s.idx = IDXW'(k);
      s.cp  = (k < NCP);
      s.sos = (k == 0);
      exp_q.push_back(s);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and log the handshakes that
  // the next rising edge will complete.
  task automatic cycle(input logic v, input logic [DW-1:0] di, input logic [DW-1:0] dq,
                       input logic rdy);
    samp_t s;
    @(negedge clk);
    io.in_valid  = v;
    io.in_i      = di;
    io.in_q      = dq;
    io.out_ready = rdy;
    #1;
    cyc++;
    s = '{i: io.out_i, q: io.out_q, idx: io.out_idx, cp: io.out_cp, sos: io.out_sos};
    if (!rst) begin
      if (prev_stall && (s !== held || io.out_valid !== 1'b1)) stall_bad++;
      prev_stall = io.out_valid && !io.out_ready;
      held       = s;
      cur_run    = io.out_valid ? cur_run + 1 : 0;
      if (cur_run > max_run) max_run = cur_run;
      if (io.out_valid && io.out_ready) begin
        if (have_prev && prev_idx == IDXW'(NSYM - 1) && s.idx == '0) wraps++;
        prev_idx  = s.idx;
        have_prev = 1'b1;
        got_q.push_back(s);
      end
      if (io.in_valid && io.in_ready) begin
        sym_i[wpos] = di;
        sym_q[wpos] = dq;
        wpos++;
        n_in++;
        if (wpos == NFFT) begin
          wpos         = 0;
          last_sym_cyc = cyc;
          push_symbol();
        end
      end
    end
  endtask

  task automatic drain(output logic timed_out);
    int n;
    n = 0;
    while ((got_q.size() < exp_q.size() || io.out_valid) && n < 2000) begin
      cycle(1'b0, '0, '0, 1'b1);
      n++;
    end
    timed_out = (n >= 2000);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst         = 1'b1;
    io.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    #1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++; if (io.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.out_idx !== '0)     begin fails++; $display("FAIL reset_out_idx got=%0d exp=0", io.out_idx); end
    checks++; if (io.in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got=%b exp=1", io.in_ready); end
    checks++; if (io.out_sos !== 1'b0 || io.out_cp !== 1'b0) begin fails++; $display("FAIL reset_flags got sos=%b cp=%b exp=0", io.out_sos, io.out_cp); end
    checks++; if (io.out_i !== '0 || io.out_q !== '0) begin fails++; $display("FAIL reset_data got i=%h q=%h exp=0", io.out_i, io.out_q); end
    $display("test_reset: done");
  endtask

  task automatic test_single_symbol();
    int   first_valid, guard, nsos;
    logic to;
    clear_model();
    first_valid = -1; guard = 0;
    while ((n_in < NFFT || guard < 8) && guard < 300) begin
      if (n_in < NFFT) cycle(1'b1, DW'(n_in), DW'(-n_in), 1'b1);
      else begin cycle(1'b0, '0, '0, 1'b1); guard++; end
      if (first_valid < 0 && io.out_valid) first_valid = cyc;
    end
    drain(to);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL single_timeout got=%b exp=0", to); end
    checks++; if (first_valid !== last_sym_cyc + 2) begin fails++; $display("FAIL single_latency got=%0d exp=%0d", first_valid - last_sym_cyc, 2); end
    checks++; if (got_q.size() !== NSYM) begin fails++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), NSYM); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL single_sample[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    nsos = 0;
    foreach (got_q[k]) if (got_q[k].sos) nsos++;
    checks++; if (nsos !== 1) begin fails++; $display("FAIL single_sos_count got=%0d exp=1", nsos); end
    $display("test_single_symbol: %0d outputs compared", got_q.size());
  endtask

  task automatic test_back_to_back();
    int   guard;
    logic to;
    clear_model();
    guard = 0;
    while (n_in < 4*NFFT && guard < 1000) begin
      cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1);
      guard++;
    end
    drain(to);
    checks++; if (to !== 1'b0 || n_in !== 4*NFFT) begin fails++; $display("FAIL b2b_timeout got_in=%0d exp_in=%0d", n_in, 4*NFFT); end
    checks++; if (max_run !== 4*NSYM) begin fails++; $display("FAIL b2b_run got=%0d exp=%0d", max_run, 4*NSYM); end
    checks++; if (wraps !== 3) begin fails++; $display("FAIL b2b_wraps got=%0d exp=3", wraps); end
    checks++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL b2b_sample[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    $display("test_back_to_back: %0d outputs compared, run=%0d", got_q.size(), max_run);
  endtask

  task automatic test_random_backpressure();
    int   guard;
    logic to;
    clear_model();
    guard = 0;
    while (n_in < 8*NFFT && guard < 5000) begin
      cycle(($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
      guard++;
    end
    drain(to);
    checks++; if (to !== 1'b0 || n_in !== 8*NFFT) begin fails++; $display("FAIL rand_timeout got_in=%0d exp_in=%0d", n_in, 8*NFFT); end
    checks++; if (stall_bad !== 0) begin fails++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (got_q.size() !== 8*NSYM) begin fails++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), 8*NSYM); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL rand_sample[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    $display("test_random_backpressure: %0d outputs compared", got_q.size());
  endtask

  task automatic test_full_stall();
    int   guard;
    logic to;
    clear_model();
    for (int c = 0; c < 200; c++) cycle(1'b1, DW'($urandom), DW'($urandom), 1'b0);
    checks++; if (n_in !== 2*NFFT) begin fails++; $display("FAIL stall_accepted got=%0d exp=%0d", n_in, 2*NFFT); end
    checks++; if (io.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", io.in_ready); end
    checks++; if (stall_bad !== 0) begin fails++; $display("FAIL stall_hold got=%0d exp=0", stall_bad); end
    guard = 0;
    while (n_in < 3*NFFT && guard < 1000) begin
      cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1);
      guard++;
    end
    drain(to);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL stall_timeout got=%b exp=0", to); end
    checks++; if (got_q.size() !== 3*NSYM) begin fails++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), 3*NSYM); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL stall_sample[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    $display("test_full_stall: %0d outputs compared", got_q.size());
  endtask

  task automatic test_reset_mid_symbol();
    int   guard;
    logic hit, to;
    clear_model();
    guard = 0; hit = 1'b0;
    while (!hit && guard < 400) begin
      cycle((n_in < 2*NFFT), DW'($urandom), DW'($urandom), 1'b1);
      hit = io.out_valid && (io.out_idx == IDXW'(30));
      guard++;
    end
    checks++; if (hit !== 1'b1) begin fails++; $display("FAIL midrst_reach_idx30 got=%b exp=1", hit); end
    apply_reset(1);
    checks++; if (io.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got=%b exp=1", io.in_ready); end
    guard = 0;
    while (n_in < NFFT && guard < 300) begin
      cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1);
      guard++;
    end
    drain(to);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL midrst_timeout got=%b exp=0", to); end
    checks++; if (got_q.size() !== NSYM) begin fails++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), NSYM); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL midrst_sample[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    $display("test_reset_mid_symbol: %0d outputs compared", got_q.size());
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.in_i      = '0;
    io.in_q      = '0;
    io.out_ready = 1'b0;
    clear_model();
    test_reset();
    test_single_symbol();
    test_back_to_back();
    test_random_backpressure();
    test_full_stall();
    test_reset_mid_symbol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
